vid_frame_reader: RTL

//  Avalon-MM burst read master fetching one video frame per vsync from frame memory (SSRAM/SDRAM)

---
 rtl/vid_frame_reader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vid_frame_reader.sv
`default_nettype none
// ============================================================================
// vid_frame_reader
// Avalon-MM burst reader: fetches one video frame per vsync and streams it out
// as Avalon-ST pixels.
// Revision: 1.0
// ============================================================================
module vid_frame_reader #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       FRAME_WORDS = 307200,
  parameter int unsigned       BURST_LEN   = 8,
  parameter int unsigned       FIFO_DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_vsync,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic [3:0]        m_burstcount,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic              underrun
);

  localparam int unsigned       PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned       CNT_W       = PTR_W + 1;
  localparam int unsigned       SUM_W       = CNT_W + 1;
  localparam int unsigned       FW_W        = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0]  BURST_CNT   = CNT_W'(BURST_LEN);
  localparam logic [FW_W-1:0]   BURST_FW    = FW_W'(BURST_LEN);
  localparam logic [FW_W-1:0]   FRAME_FW    = FW_W'(FRAME_WORDS);
  localparam logic [FW_W-1:0]   LAST_FW     = FW_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [SUM_W-1:0]  DEPTH_SUM   = SUM_W'(FIFO_DEPTH);
  localparam logic [SUM_W-1:0]  BURST_SUM   = SUM_W'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                vs_meta_q, vs_sync_q, vs_prev_q, vs_fall_q;
  logic                m_read_q, m_read_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [FW_W-1:0]     issued_q, issued_d;
  logic [FW_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                w_accept, w_rvalid, w_push, w_pop, w_can_issue;
  logic [SUM_W-1:0]    w_free, w_need;

  // vsync is idle-high, so the synchroniser resets high to avoid a false edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
      vs_fall_q <= 1'b0;
    end else begin
      vs_meta_q <= s_vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      vs_fall_q <= vs_prev_q & ~vs_sync_q;
    end
  end

  assign w_accept = m_read_q & ~m_waitrequest;
  // Data with nothing outstanding belongs to a burst cut off by reset
  assign w_rvalid = m_readdatavalid && (outstanding_q != '0);
  assign w_push   = w_rvalid && (state_q == S_RUN);
  assign st_valid = (state_q == S_RUN) && (count_q != '0);
  assign w_pop    = st_valid && st_ready;
  assign w_free   = DEPTH_SUM - SUM_W'(count_q);
  assign w_need   = SUM_W'(outstanding_q) + BURST_SUM;
  // Reserving room for everything in flight guarantees the FIFO never overflows
  assign w_can_issue = (state_q == S_RUN) && !vs_fall_q &&
                       (issued_q < FRAME_FW) && (w_free >= w_need);

  always_comb begin
    state_d       = state_q;
    m_read_d      = m_read_q;
    rd_addr_d     = rd_addr_q;
    issued_d      = issued_q;
    outstanding_d = outstanding_q + (w_accept ? BURST_CNT : '0) - CNT_W'(w_rvalid);
    wr_ptr_d      = wr_ptr_q + PTR_W'(w_push);
    rd_ptr_d      = rd_ptr_q + PTR_W'(w_pop);
    count_d       = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    pix_cnt_d     = pix_cnt_q + FW_W'(w_pop);

    if (w_accept) begin
      rd_addr_d = rd_addr_q + BURST_BYTES;
      issued_d  = issued_q + BURST_FW;
    end

    if (m_read_q) begin
      m_read_d = m_waitrequest;
    end else begin
      m_read_d = w_can_issue;
    end

    case (state_q)
      S_IDLE: begin
        if (vs_fall_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // A request still pending on the bus must be accepted and drained first
        if ((outstanding_q == '0) && !m_read_q) begin
          state_d   = S_RUN;
          rd_addr_d = BASE_ADDR;
          issued_d  = '0;
          pix_cnt_d = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
        end
      end
      S_RUN: begin
        if (vs_fall_q) state_d = S_FLUSH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      m_read_q      <= 1'b0;
      rd_addr_q     <= BASE_ADDR;
      issued_q      <= '0;
      pix_cnt_q     <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      m_read_q      <= m_read_d;
      rd_addr_q     <= rd_addr_d;
      issued_q      <= issued_d;
      pix_cnt_q     <= pix_cnt_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= m_readdata;
  end

  assign m_read       = m_read_q;
  assign m_address    = m_read_q ? rd_addr_q : '0;
  assign m_burstcount = m_read_q ? 4'(BURST_LEN) : 4'd0;
  assign st_data      = st_valid ? mem_q[rd_ptr_q] : '0;
  assign st_sop       = st_valid && (pix_cnt_q == '0);
  assign st_eop       = st_valid && (pix_cnt_q == LAST_FW);
  assign underrun     = (state_q == S_RUN) && (pix_cnt_q < FRAME_FW) &&
                        (count_q == '0) && st_ready;

endmodule
`default_nettype wire
